// File: rtl/denorm_seq_pkg.sv
// Shared types and defaults for the denormalizer: FSM state encoding,
// default widths and the iteration-counter width helper.
package denorm_seq_pkg;

    localparam int unsigned S_DEF = 8;
    localparam int unsigned W_DEF = 20;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

endpackage

// File: rtl/denorm_step.sv
// One shift-and-add multiplier iteration: conditionally add M to the partial
// product, then shift the {A,Q} pair right by one bit.
module denorm_step
    import denorm_seq_pkg::*;
#(
    parameter int unsigned S = S_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic [W:0]   a,
    input  logic [S-1:0] q,
    input  logic [W-1:0] m,
    output logic [W:0]   a_nx,
    output logic [S-1:0] q_nx
);

    logic [W:0]     sum;
    logic [W+S:0]   pair;

    always_comb begin
        sum  = a + (q[0] ? {1'b0, m} : '0);
        pair = {sum, q} >> 1;
        a_nx = pair[W+S:S];
        q_nx = pair[S-1:0];
    end

endmodule

// File: rtl/denorm_seq.sv
// Sequential denormalizer: count_dn = floor(val_nm * max / 2^S), computed with
// one shift-and-add iteration per enabled cycle behind a start/ready handshake.
module denorm_seq
    import denorm_seq_pkg::*;
#(
    parameter int unsigned S = S_DEF,
    parameter int unsigned W = W_DEF
) (
    input  logic         MHz10,
    input  logic         nrst,
    input  logic         en,
    input  logic         start,
    input  logic [S-1:0] val_nm,
    input  logic [W-1:0] max,
    output logic [W-1:0] count_dn,
    output logic         ready,
    output logic         busy
);

    localparam int unsigned   CW   = cnt_w(S);
    localparam logic [CW-1:0] LAST = CW'(S - 1);

    state_t        state, state_nx;
    logic [W:0]    a_r, a_nx;
    logic [S-1:0]  q_r, q_nx;
    logic [W-1:0]  m_r;
    logic [CW-1:0] cnt_r;
    logic          accept, adv, last;

    assign accept = en & start & (state == IDLE);
    assign adv    = en & (state == RUN);
    assign last   = (cnt_r == LAST);

    denorm_step #(.S(S), .W(W)) u_step (
        .a    (a_r),
        .q    (q_r),
        .m    (m_r),
        .a_nx (a_nx),
        .q_nx (q_nx)
    );

    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en && start) state_nx = RUN;
            RUN:     if (en && last)  state_nx = DONE;
            DONE:    if (en)          state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE: begin
                busy  = 1'b1;
                ready = en;
            end
            default: ;
        endcase
    end

    // The result register is loaded on the final RUN iteration so that it
    // already shows the new value in the cycle ready is asserted.
    always_ff @(posedge MHz10 or negedge nrst) begin
        if (!nrst) begin
            a_r      <= '0;
            q_r      <= '0;
            m_r      <= '0;
            cnt_r    <= '0;
            count_dn <= '0;
        end else if (accept) begin
            a_r   <= '0;
            q_r   <= val_nm;
            m_r   <= max;
            cnt_r <= '0;
        end else if (adv) begin
            a_r   <= a_nx;
            q_r   <= q_nx;
            cnt_r <= cnt_r + CW'(1);
            if (last) count_dn <= a_nx[W-1:0];
        end
    end

endmodule

// File: tb/tb_denorm_seq.sv
// Self-checking bench for denorm_seq: directed scenarios plus randomized
// operations checked against floor(val*max/256) and the cycle-count rules.
module tb_denorm_seq;

    logic        MHz10 = 1'b0;
    logic        nrst  = 1'b0;
    logic        en    = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  val_nm = '0;
    logic [19:0] max   = '0;
    logic [19:0] count_dn;
    logic        ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    denorm_seq #(.S(8), .W(20)) dut (
        .MHz10    (MHz10),
        .nrst     (nrst),
        .en       (en),
        .start    (start),
        .val_nm   (val_nm),
        .max      (max),
        .count_dn (count_dn),
        .ready    (ready),
        .busy     (busy)
    );

    always #5 MHz10 = ~MHz10;

    function automatic logic [19:0] ref_prod(input logic [7:0] v, input logic [19:0] m);
        longint unsigned p;
        p = longint'(v) * longint'(m);
        return 20'(p / 256);
    endfunction

    // Runs one operation; cycle 0 is the start cycle. lowmask bit c drops en in
    // cycle c. An extra start can be injected in cycle xc with operands xv/xm.
    task automatic op(input logic [7:0] v, input logic [19:0] m, input logic [47:0] lowmask,
                      input int xc, input logic [7:0] xv, input logic [19:0] xm,
                      output int rc, output logic [19:0] res,
                      output int busy_err, output int hold_err);
        logic [19:0] prev;
        prev = count_dn;
        rc = -1; res = '0; busy_err = 0; hold_err = 0;
        for (int c = 0; c < 48; c++) begin
            @(posedge MHz10); #1;
            start  = (c == 0) || (c == xc);
            val_nm = (c == xc) ? xv : ((c == 0) ? v : 8'($urandom));
            max    = (c == xc) ? xm : ((c == 0) ? m : 20'($urandom));
            en     = !lowmask[c];
            #1;
            if (busy !== (c >= 1)) busy_err++;
            if (ready === 1'b1) begin
                rc  = c;
                res = count_dn;
                break;
            end
            if (c <= 8 && count_dn !== prev) hold_err++;
        end
        start = 1'b0;
        en    = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(posedge MHz10);
        #2;
        total++;
        if (count_dn !== 20'd0 || ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: count_dn=%0d ready=%b busy=%b, required 0/0/0", count_dn, ready, busy);
        end
        @(negedge MHz10);
        nrst = 1'b1;
        en   = 1'b1;
    endtask

    task automatic test_nominal();
        int rc, be, he;
        logic [19:0] res;
        op(8'd128, 20'd1000, '0, -1, '0, '0, rc, res, be, he);
        total++;
        if (rc !== 9 || res !== 20'd500 || be !== 0) begin
            bad++;
            $display("FAIL nominal: cycle=%0d value=%0d busy_err=%0d, required 9/500/0", rc, res, be);
        end
        @(posedge MHz10); #2;
        total++;
        if (ready !== 1'b0 || busy !== 1'b0 || count_dn !== 20'd500) begin
            bad++;
            $display("FAIL after_ready: ready=%b busy=%b count_dn=%0d, required 0/0/500", ready, busy, count_dn);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0]  vs [4] = '{8'd255, 8'd1,   8'd0,     8'd200};
        logic [19:0] ms [4] = '{20'hFFFFF, 20'd255, 20'd12345, 20'd0};
        logic [19:0] ex [4] = '{20'hFEFFF, 20'd0,   20'd0,     20'd0};
        int rc, be, he;
        logic [19:0] res;
        for (int i = 0; i < 4; i++) begin
            op(vs[i], ms[i], '0, -1, '0, '0, rc, res, be, he);
            total++;
            if (rc !== 9 || res !== ex[i] || be !== 0) begin
                bad++;
                $display("FAIL boundary[%0d]: cycle=%0d value=%0h busy_err=%0d, required 9/%0h/0", i, rc, res, be, ex[i]);
            end
        end
    endtask

    task automatic test_stall();
        int rc, be, he;
        logic [19:0] res;
        op(8'd64, 20'd4000, 48'h38, -1, '0, '0, rc, res, be, he);
        total++;
        if (rc !== 12 || res !== 20'd1000 || be !== 0) begin
            bad++;
            $display("FAIL stall_run: cycle=%0d value=%0d busy_err=%0d, required 12/1000/0", rc, res, be);
        end
        op(8'd64, 20'd4000, 48'h600, -1, '0, '0, rc, res, be, he);
        total++;
        if (rc !== 11 || res !== 20'd1000 || be !== 0) begin
            bad++;
            $display("FAIL stall_done: cycle=%0d value=%0d busy_err=%0d, required 11/1000/0", rc, res, be);
        end
    endtask

    task automatic test_start_en_low();
        int seen;
        @(posedge MHz10); #1;
        start = 1'b1; en = 1'b0; val_nm = 8'd99; max = 20'd777;
        @(posedge MHz10); #1;
        start = 1'b0; en = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL start_en_low_busy: busy=%b, required 0", busy);
        end
        seen = 0;
        repeat (12) begin
            @(posedge MHz10); #2;
            if (ready === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL start_en_low_ready: pulses=%0d, required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int rc, be, he;
        logic [19:0] res;
        op(8'd128, 20'd1000, '0, 4, 8'd10, 20'd3333, rc, res, be, he);
        total++;
        if (rc !== 9 || res !== 20'd500 || be !== 0) begin
            bad++;
            $display("FAIL busy_start: cycle=%0d value=%0d busy_err=%0d, required 9/500/0", rc, res, be);
        end
        op(8'd64, 20'd1000, '0, -1, '0, '0, rc, res, be, he);
        total++;
        if (rc !== 9 || res !== 20'd250 || be !== 0 || he !== 0) begin
            bad++;
            $display("FAIL back_to_back: cycle=%0d value=%0d busy_err=%0d hold_err=%0d, required 9/250/0/0", rc, res, be, he);
        end
    endtask

    task automatic test_reset_mid_op();
        int rc, be, he, seen;
        logic [19:0] res;
        @(posedge MHz10); #1;
        start = 1'b1; en = 1'b1; val_nm = 8'd200; max = 20'd50000;
        for (int c = 1; c < 5; c++) begin
            @(posedge MHz10); #1;
            start = 1'b0;
        end
        @(posedge MHz10); #3;
        nrst = 1'b0;
        #1;
        total++;
        if (count_dn !== 20'd0 || busy !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_op: count_dn=%0d busy=%b ready=%b, required 0/0/0", count_dn, busy, ready);
        end
        @(negedge MHz10);
        @(negedge MHz10);
        nrst = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge MHz10); #2;
            if (ready === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_abort: activity_cycles=%0d, required 0", seen);
        end
        op(8'd77, 20'd123456, '0, -1, '0, '0, rc, res, be, he);
        total++;
        if (rc !== 9 || res !== ref_prod(8'd77, 20'd123456) || be !== 0) begin
            bad++;
            $display("FAIL after_reset_op: cycle=%0d value=%0d busy_err=%0d, required 9/%0d/0", rc, res, be, ref_prod(8'd77, 20'd123456));
        end
    endtask

    task automatic test_random();
        int rc, be, he, stalls;
        logic [19:0] res, m;
        logic [7:0]  v;
        logic [47:0] mask;
        for (int i = 0; i < 25; i++) begin
            v = 8'($urandom);
            m = 20'($urandom);
            case ($urandom % 6)
                0: v = 8'd0;
                1: m = 20'd0;
                2: v = 8'd255;
                default: ;
            endcase
            mask = '0;
            stalls = 0;
            for (int c = 1; c <= 9; c++) begin
                if ($urandom % 5 == 0) begin
                    mask[c] = 1'b1;
                    stalls++;
                end
            end
            op(v, m, mask, -1, '0, '0, rc, res, be, he);
            total++;
            if (rc !== 9 + stalls || res !== ref_prod(v, m) || be !== 0) begin
                bad++;
                $display("FAIL random[%0d] v=%0d m=%0d: cycle=%0d value=%0d busy_err=%0d, required %0d/%0d/0",
                         i, v, m, rc, res, be, 9 + stalls, ref_prod(v, m));
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_boundaries();
        test_stall();
        test_start_en_low();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
